// File: rtl/delay_timer_arbiter.sv
// Shared delay timer: arbitrates N_REQ requesters onto one prescaler + tick counter.
// Latency: grant 1 cycle after request; done pulse TICK_DIV*DELAY_TICKS+1 cycles after grant.
// Backpressure: level requests stay pending while busy; HOLD waits for the winner to release.
//
// Ports:
//   clk_50M  - system clock, rising edge
//   i_Reset  - synchronous, active-high reset
//   i_Req    - level request per requester, held until done or abort
//   o_Grant  - registered one-hot grant
//   o_Done   - one-cycle done pulse to the granted requester
//   o_Busy   - timer owned (RUN/DONE/HOLD)
//   o_Tick   - one-cycle pulse per elapsed tick while running
//   o_Count  - elapsed ticks of the current or last delay
//
// Build option: define TIMER_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer); default build is round-robin.
module delay_timer_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TICK_DIV    = 25000,
  parameter int DELAY_TICKS = 4000,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                 clk_50M,
  input  logic                 i_Reset,
  input  logic [N_REQ-1:0]     i_Req,
  output logic [N_REQ-1:0]     o_Grant,
  output logic [N_REQ-1:0]     o_Done,
  output logic                 o_Busy,
  output logic                 o_Tick,
  output logic [CNT_WIDTH-1:0] o_Count
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DELAY_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     owner_q, owner_d;   // winner kept through HOLD after o_Grant clears
  logic [N_REQ-1:0]     done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tick_q, tick_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] count_inc;

  logic                 win_vld;
  logic [PTR_W-1:0]     win_idx;
  logic [N_REQ-1:0]     win_oh;

`ifdef TIMER_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_Req[i]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] scan_idx;
  int               scan_sum;

  // Scan offsets from the pointer, descending, so the smallest cyclic offset wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_sum = 0;
    scan_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_sum = (int'(rr_ptr_q) + i) % N_REQ;
      scan_idx = PTR_W'(scan_sum);
      if (i_Req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && win_vld) begin
      rr_ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    win_oh = '0;
    if (win_vld) begin
      win_oh[win_idx] = 1'b1;
    end
  end

  assign count_inc = count_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    done_d  = '0;
    tick_d  = 1'b0;
    presc_d = presc_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = win_oh;
          owner_d = win_oh;
          presc_d = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort takes precedence over a coincident final tick; count holds.
        if ((i_Req & owner_q) == '0) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (presc_q == PRE_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          count_d = count_inc;
          if (count_inc == CNT_LAST) begin
            state_d = S_DONE;
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      S_DONE: begin
        done_d  = grant_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        grant_d = '0;
        // Wait for the winner to release so a held request cannot retrigger.
        if ((i_Req & owner_q) == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      presc_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign o_Grant = grant_q;
  assign o_Done  = done_q;
  assign o_Busy  = busy_q;
  assign o_Tick  = tick_q;
  assign o_Count = count_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: directed scenarios plus random requests.
// Reference model tracks elapsed cycles since grant rather than a prescaler.
// Honours TIMER_ARB_FIXED_PRIO_EN when the build defines it.
module tb_delay_timer_arbiter;
  localparam int N  = 3;
  localparam int TD = 4;
  localparam int DT = 3;
  localparam int CW = 4;

  logic          clk_50M = 1'b0;
  logic          i_Reset;
  logic [N-1:0]  i_Req;
  logic [N-1:0]  o_Grant, o_Done;
  logic          o_Busy, o_Tick;
  logic [CW-1:0] o_Count;

  always #5 clk_50M = ~clk_50M;

  delay_timer_arbiter #(
    .N_REQ(N), .TICK_DIV(TD), .DELAY_TICKS(DT), .CNT_WIDTH(CW)
  ) dut (
    .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Req(i_Req),
    .o_Grant(o_Grant), .o_Done(o_Done), .o_Busy(o_Busy),
    .o_Tick(o_Tick), .o_Count(o_Count)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 running, 2 delay expired, 3 waiting for release.
  int            m_phase = 0;
  int            m_owner = 0;
  int            m_t     = 0;
  int            m_ptr   = 0;
  logic [N-1:0]  e_grant = '0, e_done = '0;
  logic          e_busy  = 1'b0, e_tick = 1'b0;
  logic [CW-1:0] e_count = '0;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic rst);
    int w;
    e_done = '0;
    e_tick = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0;
      e_grant = '0; e_busy = 1'b0; e_count = '0;
    end else begin
      case (m_phase)
        0: begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
          w = pick(r, 0);
`else
          w = pick(r, m_ptr);
`endif
          if (w >= 0) begin
            m_owner = w; m_t = 0; m_ptr = (w + 1) % N;
            e_grant = '0; e_grant[w] = 1'b1;
            e_busy = 1'b1; e_count = '0; m_phase = 1;
          end
        end
        1: begin
          if (!r[m_owner]) begin
            m_phase = 0; e_grant = '0; e_busy = 1'b0;
          end else begin
            m_t++;
            if (m_t % TD == 0) begin
              e_tick = 1'b1;
              e_count = CW'(m_t / TD);
            end
            if (m_t == TD * DT) m_phase = 2;
          end
        end
        2: begin
          e_done = e_grant; m_phase = 3;
        end
        default: begin
          e_grant = '0;
          if (!r[m_owner]) begin
            m_phase = 0; e_busy = 1'b0;
          end
        end
      endcase
    end
  endtask

  // Drive inputs, advance one edge, update model, settle 1 time unit past the edge.
  task automatic cyc(input logic [N-1:0] r, input logic rst);
    i_Req = r;
    i_Reset = rst;
    @(posedge clk_50M);
    model_step(r, rst);
    #1;
  endtask

  task automatic test_reset();
    cyc('0, 1'b1);
    cyc('0, 1'b1);
    checks++;
    if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h want 000", {o_Grant, o_Done, o_Busy, o_Tick, o_Count});
    end
    cyc('0, 1'b0);
  endtask

  task automatic test_single();
    int g = -1, d = -1;
    int tk[$];
    int tc[$];
    for (int k = 0; k < 20; k++) begin
      cyc(3'b001, 1'b0);
      checks++;
      if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== {e_grant, e_done, e_busy, e_tick, e_count}) begin
        errors++;
        $display("FAIL single_model k=%0d got %h want %h", k, {o_Grant, o_Done, o_Busy, o_Tick, o_Count}, {e_grant, e_done, e_busy, e_tick, e_count});
      end
      if (o_Grant == 3'b001 && g < 0) g = k;
      if (o_Done != 3'b000) d = k;
      if (o_Tick) begin tk.push_back(k); tc.push_back(int'(o_Count)); end
    end
    checks++;
    if (g != 0) begin errors++; $display("FAIL single_grant_latency got %0d want 0", g); end
    checks++;
    if (d - g != 13) begin errors++; $display("FAIL single_done_offset got %0d want 13", d - g); end
    checks++;
    if (tk.size() != 3) begin
      errors++; $display("FAIL single_tick_count got %0d want 3", tk.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tk[i] != TD * (i + 1) || tc[i] != i + 1) begin
          errors++;
          $display("FAIL single_tick_%0d got k=%0d cnt=%0d want k=%0d cnt=%0d", i, tk[i], tc[i], TD * (i + 1), i + 1);
        end
      end
    end
    cyc(3'b000, 1'b0);
    checks++;
    if (o_Busy !== 1'b0 || o_Grant !== 3'b000) begin
      errors++; $display("FAIL single_release got busy=%b grant=%b want 0 000", o_Busy, o_Grant);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rq;
    logic [N-1:0] prev_g;
    logic [N-1:0] order[$];
    logic [N-1:0] want[4];
`ifdef TIMER_ARB_FIXED_PRIO_EN
    want = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    want = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    cyc('0, 1'b1);
    rq = 3'b111;
    prev_g = '0;
    for (int k = 0; k < 100 && order.size() < 4; k++) begin
      cyc(rq, 1'b0);
      checks++;
      if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== {e_grant, e_done, e_busy, e_tick, e_count}) begin
        errors++;
        $display("FAIL rr_model k=%0d got %h want %h", k, {o_Grant, o_Done, o_Busy, o_Tick, o_Count}, {e_grant, e_done, e_busy, e_tick, e_count});
      end
      if (prev_g == '0 && o_Grant != '0) order.push_back(o_Grant);
      prev_g = o_Grant;
      rq = 3'b111 & ~o_Done;
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL rr_grant_count got %0d want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] !== want[i]) begin
          errors++; $display("FAIL rr_order_%0d got %b want %b", i, order[i], want[i]);
        end
      end
    end
    cyc('0, 1'b0);
    cyc('0, 1'b0);
  endtask

  task automatic test_abort();
    logic saw_done = 1'b0;
    cyc(3'b000, 1'b0);
    cyc(3'b010, 1'b0);
    for (int k = 0; k < 6; k++) cyc(3'b010, 1'b0);
    cyc(3'b000, 1'b0);
    checks++;
    if (o_Grant !== 3'b000 || o_Count !== CW'(1) || o_Done !== 3'b000 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got grant=%b cnt=%0d done=%b busy=%b want 000 1 000 0", o_Grant, o_Count, o_Done, o_Busy);
    end
    for (int k = 0; k < 15; k++) begin
      cyc(3'b000, 1'b0);
      if (o_Done != '0 || o_Count !== CW'(1)) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_after got done/count change want none"); end
  endtask

  task automatic test_abort_final();
    cyc(3'b001, 1'b0);
    for (int k = 0; k < 11; k++) cyc(3'b001, 1'b0);
    checks++;
    if (o_Count !== CW'(2)) begin errors++; $display("FAIL abortfin_pre got cnt=%0d want 2", o_Count); end
    cyc(3'b000, 1'b0);
    checks++;
    if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== {3'b000, 3'b000, 1'b0, 1'b0, CW'(2)}) begin
      errors++;
      $display("FAIL abortfin_state got %h want %h", {o_Grant, o_Done, o_Busy, o_Tick, o_Count}, {3'b000, 3'b000, 1'b0, 1'b0, CW'(2)});
    end
    cyc(3'b000, 1'b0);
    checks++;
    if (o_Done !== 3'b000) begin errors++; $display("FAIL abortfin_nodone got %b want 000", o_Done); end
    cyc(3'b001, 1'b0);
    checks++;
    if (o_Grant !== 3'b001) begin errors++; $display("FAIL abortfin_idle_regrant got %b want 001", o_Grant); end
    cyc(3'b000, 1'b0);
  endtask

  task automatic test_reset_mid();
    int d = -1;
    cyc(3'b000, 1'b0);
    cyc(3'b001, 1'b0);
    for (int k = 0; k < 20 && o_Count != CW'(2); k++) cyc(3'b001, 1'b0);
    checks++;
    if (o_Count !== CW'(2)) begin errors++; $display("FAIL resetmid_reach got cnt=%0d want 2", o_Count); end
    cyc(3'b001, 1'b1);
    checks++;
    if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== 12'h000) begin
      errors++; $display("FAIL resetmid_outputs got %h want 000", {o_Grant, o_Done, o_Busy, o_Tick, o_Count});
    end
    cyc(3'b100, 1'b0);
    checks++;
    if (o_Grant !== 3'b100) begin errors++; $display("FAIL resetmid_grant got %b want 100", o_Grant); end
    for (int k = 1; k < 16; k++) begin
      cyc(3'b100, 1'b0);
      checks++;
      if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== {e_grant, e_done, e_busy, e_tick, e_count}) begin
        errors++;
        $display("FAIL resetmid_model k=%0d got %h want %h", k, {o_Grant, o_Done, o_Busy, o_Tick, o_Count}, {e_grant, e_done, e_busy, e_tick, e_count});
      end
      if (o_Done == 3'b100) d = k;
    end
    checks++;
    if (d != 13) begin errors++; $display("FAIL resetmid_done_offset got %0d want 13", d); end
    cyc(3'b000, 1'b0);
  endtask

  task automatic test_hold_guard();
    logic bad = 1'b0;
    cyc(3'b000, 1'b0);
    cyc(3'b001, 1'b0);
    for (int k = 0; k < 14; k++) cyc(3'b001, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(3'b001, 1'b0);
      if (o_Grant != '0 || o_Done != '0 || o_Busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL hold_no_regrant got regrant/done/idle want held"); end
    cyc(3'b000, 1'b0);
    cyc(3'b001, 1'b0);
    for (int k = 0; k < 13; k++) cyc(3'b011, 1'b0);
    checks++;
    if (o_Done !== 3'b001) begin errors++; $display("FAIL hold_pending_done got %b want 001", o_Done); end
    cyc(3'b010, 1'b0);
    checks++;
    if (o_Grant !== 3'b000 || o_Busy !== 1'b0) begin
      errors++; $display("FAIL hold_gap got grant=%b busy=%b want 000 0", o_Grant, o_Busy);
    end
    cyc(3'b010, 1'b0);
    checks++;
    if (o_Grant !== 3'b010) begin errors++; $display("FAIL hold_pending_grant got %b want 010", o_Grant); end
    cyc(3'b000, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] rq = '0;
    logic         rst;
    int           grants = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(15) == 0) rq[b] = ~rq[b];
      rst = ($urandom_range(399) == 0);
      cyc(rq, rst);
      checks++;
      if ({o_Grant, o_Done, o_Busy, o_Tick, o_Count} !== {e_grant, e_done, e_busy, e_tick, e_count}) begin
        errors++;
        $display("FAIL random_model k=%0d req=%b rst=%b got %h want %h", k, rq, rst, {o_Grant, o_Done, o_Busy, o_Tick, o_Count}, {e_grant, e_done, e_busy, e_tick, e_count});
      end
      if (o_Done != '0) grants++;
    end
    checks++;
    if (grants == 0) begin errors++; $display("FAIL random_activity got 0 completed delays want >0"); end
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_abort_final();
    test_reset_mid();
    test_hold_guard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shared 2-second delay-timer controller for the BlackJack game. One internal tick prescaler and one tick counter are time-shared between up to `N_REQ` requesters, such as the game FSM, the dealer-turn pacing and the display hold. The block arbitrates requests, sequences clear, count and terminate on the shared counter, and returns a one-cycle done pulse to the granted requester. It sits between the game FSM and the display/output logic and replaces per-client timers.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters (≥2).
- `TICK_DIV`, default 25000: `clk_50M` cycles per tick (50 MHz / 2 kHz).
- `DELAY_TICKS`, default 4000: ticks per delay (2 s at 2 kHz).
- `CNT_WIDTH`, default 12: tick-counter width. Must satisfy 2^`CNT_WIDTH` > `DELAY_TICKS`.

Ports (reset i_Reset, synchronous, active-high; clock clk_50M):
- `clk_50M`  in  1  system clock, all logic on the rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Req`  in  `N_REQ`  level request per requester; the requester holds it until done or abort.
- `o_Grant`  out  `N_REQ`  one-hot grant, registered.
- `o_Done`  out  `N_REQ`  one-cycle pulse to the granted requester when its delay expires.
- `o_Busy`  out  1  timer owned (states RUN/DONE/HOLD).
- `o_Tick`  out  1  one-cycle pulse per elapsed tick while in RUN.
- `o_Count`  out  `CNT_WIDTH`  elapsed ticks of the current or last delay.

## Operation
- States: IDLE, RUN, DONE, HOLD.
- Reset: state IDLE, rr-pointer=0, prescaler=0. All outputs 0: `o_Grant`, `o_Done`, `o_Busy`, `o_Tick` and `o_Count`.
- IDLE:
  - If any `i_Req` bit is set, select the winner: the first set bit at or after the rr-pointer, cyclically.
  - Load `o_Grant` with the winner, clear the prescaler and `o_Count`, go to RUN.
  - Set the rr-pointer to winner+1 mod `N_REQ`.
- RUN:
  - The prescaler counts 0..`TICK_DIV`-1 and wraps.
  - At wrap, pulse `o_Tick` and increment `o_Count`.
  - When the increment makes `o_Count`=`DELAY_TICKS`, go to DONE.
- DONE:
  - `o_Done` = `o_Grant` for exactly this one cycle, then go to HOLD.
- HOLD:
  - Clear `o_Grant`.
  - Stay until the winner's `i_Req` is low, then go to IDLE. This prevents re-triggering on a held request.
- Abort: the granted `i_Req` goes low in RUN → IDLE next cycle. `o_Grant` clears, there is no `o_Done`, and `o_Count` holds its value.
- Abort and the final tick in the same cycle: abort wins, no `o_Done`.
- Other requests during RUN/DONE/HOLD stay pending and are not dropped. They are arbitrated on the next IDLE cycle.
- `i_Reset` mid-operation: immediate return to the reset state. No `o_Done` is emitted.
- `o_Count` never exceeds `DELAY_TICKS`. No wrap-around is possible under the width rule.
- The prescaler width is $clog2(`TICK_DIV`).

## Timing
- Request sampled in IDLE at edge E:
  - `o_Grant` and `o_Busy` are high from E.
  - `o_Tick` is high in the cycle after edges E+k·`TICK_DIV`, for k=1..`DELAY_TICKS`.
- `o_Done` is high for the cycle after edge E+`TICK_DIV`·`DELAY_TICKS`+1, which is the DONE state.
- HOLD→IDLE takes one cycle after the request drops. A pending request is granted on the following edge, so the minimum gap between grants is 2 cycles after the request drops.
- Request-to-grant latency: 1 cycle.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- `TIMER_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins, and the rr-pointer logic is removed.
- Not defined: round-robin as described above.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `DELAY_TICKS`=3, `N_REQ`=3.
1. Single delay: `i_Req`=001 held → `o_Grant`=001 after 1 cycle. `o_Tick` pulses every 4 cycles, `o_Count` steps 1,2,3. `o_Done`=001 for one cycle 13 cycles after the grant edge. Releasing the request then returns `o_Busy`=0.
2. Round-robin: `i_Req`=111 held, and each requester drops and re-raises its request after its done → grants 001, 010, 100, 001 in order.
   - With `TIMER_ARB_FIXED_PRIO_EN` defined: 001 is granted repeatedly.
3. Abort: `i_Req`=010, dropped after 6 cycles in RUN → `o_Grant`=000 the next cycle, no `o_Done`, `o_Count`=1 held.
4. Abort on the final tick: drop the request in the cycle of the 3rd wrap → no `o_Done`, state IDLE.
5. Reset mid-RUN: assert `i_Reset` at `o_Count`=2 → next cycle all outputs are 0. A subsequent `i_Req`=100 is granted via pointer 0 and gets a full 12-cycle delay.
6. Hold guard: `i_Req`=001 kept high after done → no regrant. `i_Req`=011 pending during RUN of 001 → 010 is granted 2 cycles after 001 drops.
